dfu_lsc_sequencer: RTL and testbench
====================================

DFU_LSC_SEQUENCER -- requirements
Module: dfu_lsc_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 256: width of every instruction word.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit per execution phase; used only when LSC_TIMEOUT_EN is defined.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 idu2dfu_load_fifo_empty / idu2dfu_compute_fifo_empty / idu2dfu_store_fifo_empty  in  1 each  high when that IDU queue has nothing to give.
REQ-007 dfu2idu_load_instr_req / dfu2idu_compute_instr_req / dfu2idu_store_instr_req  out  1 each  one-cycle read request to that IDU queue.
REQ-008 idu2dfu_load_instr / idu2dfu_compute_instr / idu2dfu_store_instr  in  INSTR_WIDTH each  instruction data.
REQ-009 idu2dfu_load_instr_vld / idu2dfu_compute_instr_vld / idu2dfu_store_instr_vld  in  1 each  data qualifier.
REQ-010 load_start / compute_start / store_start  out  1 each  one-cycle engine start pulse.
REQ-011 load_instr / compute_instr / store_instr  out  INSTR_WIDTH each  captured instruction, held stable from capture until the next capture.
REQ-012 load_done / compute_done / store_done  in  1 each  engine completion pulse.
REQ-013 dfu_lsc_done  out  1  one-cycle pulse when a load-compute-store triple completes.
REQ-014 lsc_busy  out  1  high in every state except IDLE.
REQ-015 lsc_timeout_err  out  1  sticky watchdog error flag.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, LOAD, COMPUTE, STORE, DONE.
REQ-017 IDLE: when all three *_fifo_empty are low, SHALL assert all three *_instr_req for exactly one cycle and go to FETCH; otherwise no request.
REQ-018 FETCH: SHALL capture each instruction on the cycle its *_vld is high and set a per-queue got flag; arrivals may be in any order or cycle.
REQ-019 FETCH: SHALL go to LOAD on the cycle after all three got flags are set; *_vld seen in any other state SHALL be ignored.
REQ-020 On entry to LOAD, COMPUTE or STORE, SHALL pulse the matching *_start for one cycle, in the entry cycle.
REQ-021 The matching *_done SHALL be sampled only from the cycle after *_start; *_done in the start cycle or in other states SHALL be ignored.
REQ-022 Transitions SHALL be LOAD->COMPUTE on load_done, COMPUTE->STORE on compute_done, and STORE->DONE on store_done.
REQ-023 DONE: SHALL pulse dfu_lsc_done for one cycle, clear the got flags, and return to IDLE.
REQ-024 The next request SHALL be issued no earlier than the cycle after DONE, giving a 1-cycle IDLE gap minimum.
REQ-025 Minimum latency from IDLE request to dfu_lsc_done SHALL be 1 FETCH cycle + 2 cycles per phase + 1 DONE cycle, given vld at req+1 and done at start+1.
REQ-026 *_instr outputs SHALL NOT change while in LOAD, COMPUTE or STORE.

Reset
REQ-027 On rst low, SHALL asynchronously enter IDLE.
REQ-028 On rst low, SHALL clear all got flags and the watchdog counter.
REQ-029 On rst low, SHALL drive all req, start, dfu_lsc_done, lsc_busy and lsc_timeout_err outputs to 0, and all *_instr outputs to 0.
REQ-030 Reset mid-operation SHALL discard any captured instructions; no pulse SHALL be emitted on reset release.

Configuration
REQ-031 Macro LSC_TIMEOUT_EN, when defined, SHALL enable a watchdog counter that clears on entry to LOAD, COMPUTE or STORE and increments each cycle while in those states.
REQ-032 With LSC_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES: lsc_timeout_err SHALL set (sticky until reset) and the FSM SHALL return to IDLE without pulsing dfu_lsc_done.
REQ-033 With LSC_TIMEOUT_EN undefined, no counter SHALL exist, lsc_timeout_err SHALL be tied 0, and the FSM SHALL wait indefinitely for *_done.

Verification
REQ-034 All empties low at cycle 0, vlds at cycle 2, each done 1 cycle after start -> single req pulse, starts in order L/C/S, one dfu_lsc_done, instrs match 0xA.., 0xB.., 0xC...
REQ-035 Store empty held high for 10 cycles, others low -> no req until store empty falls, then all three reqs together.
REQ-036 vlds arrive store(cycle 2), load(cycle 5), compute(cycle 7) -> load_start occurs at cycle 8; data correctly captured.
REQ-037 compute_done asserted in the compute_start cycle and again 3 cycles later -> first ignored, STORE entered after the second.
REQ-038 rst low during COMPUTE -> outputs 0 immediately; after release the sequencer is idle, with no start or done pulses until a new fetch.
REQ-039 LSC_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, load_done never asserted -> lsc_timeout_err high 16 cycles after LOAD entry, FSM back to IDLE, no dfu_lsc_done.

Source files
------------

// File: rtl/dfu_lsc_sequencer.sv
// Load/compute/store sequencer: fetches one instruction triple from the IDU and runs the three engines in order.
// Optional watchdog per execution phase is compiled in with `define LSC_TIMEOUT_EN.
module dfu_lsc_sequencer #(
  parameter int INSTR_WIDTH    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idu2dfu_load_fifo_empty,
  input  logic                   idu2dfu_compute_fifo_empty,
  input  logic                   idu2dfu_store_fifo_empty,
  output logic                   dfu2idu_load_instr_req,
  output logic                   dfu2idu_compute_instr_req,
  output logic                   dfu2idu_store_instr_req,
  input  logic [INSTR_WIDTH-1:0] idu2dfu_load_instr,
  input  logic [INSTR_WIDTH-1:0] idu2dfu_compute_instr,
  input  logic [INSTR_WIDTH-1:0] idu2dfu_store_instr,
  input  logic                   idu2dfu_load_instr_vld,
  input  logic                   idu2dfu_compute_instr_vld,
  input  logic                   idu2dfu_store_instr_vld,
  output logic                   load_start,
  output logic                   compute_start,
  output logic                   store_start,
  output logic [INSTR_WIDTH-1:0] load_instr,
  output logic [INSTR_WIDTH-1:0] compute_instr,
  output logic [INSTR_WIDTH-1:0] store_instr,
  input  logic                   load_done,
  input  logic                   compute_done,
  input  logic                   store_done,
  output logic                   dfu_lsc_done,
  output logic                   lsc_busy,
  output logic                   lsc_timeout_err
);

  localparam int NQ = 3;  // lane 0 load, 1 compute, 2 store

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, COMPUTE, STORE, DONE} state_t;

  state_t                         state, state_nxt;
  logic [NQ-1:0]                  vld, got, done_in, start_q, start_nxt;
  logic [NQ-1:0][INSTR_WIDTH-1:0] instr_in, instr_q;
  logic                           all_ready, in_phase, tmo, req;

  assign vld      = {idu2dfu_store_instr_vld, idu2dfu_compute_instr_vld, idu2dfu_load_instr_vld};
  assign instr_in = {idu2dfu_store_instr, idu2dfu_compute_instr, idu2dfu_load_instr};
  assign done_in  = {store_done, compute_done, load_done};
  assign all_ready = ~(idu2dfu_load_fifo_empty | idu2dfu_compute_fifo_empty |
                       idu2dfu_store_fifo_empty);
  assign in_phase  = (state == LOAD) || (state == COMPUTE) || (state == STORE);

  // Done is only honoured once the start pulse has gone (start_q low).
  always_comb begin
    state_nxt = state;
    start_nxt = '0;
    unique case (state)
      IDLE:    if (all_ready) state_nxt = FETCH;
      FETCH:   if (&(got | vld)) state_nxt = LOAD;
      LOAD:    if (done_in[0] && !start_q[0]) state_nxt = COMPUTE;
               else if (tmo) state_nxt = IDLE;
      COMPUTE: if (done_in[1] && !start_q[1]) state_nxt = STORE;
               else if (tmo) state_nxt = IDLE;
      STORE:   if (done_in[2] && !start_q[2]) state_nxt = DONE;
               else if (tmo) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    start_nxt[0] = (state_nxt == LOAD)    && (state != LOAD);
    start_nxt[1] = (state_nxt == COMPUTE) && (state != COMPUTE);
    start_nxt[2] = (state_nxt == STORE)   && (state != STORE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      start_q <= '0;
      got     <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      for (int i = 0; i < NQ; i++) begin
        if (state_nxt == IDLE)
          got[i] <= 1'b0;
        else if (state == FETCH && vld[i] && !got[i]) begin
          got[i]     <= 1'b1;
          instr_q[i] <= instr_in[i];
        end
      end
    end
  end

  // Request is a Mealy output of IDLE; gating with rst keeps it low while reset is held.
  assign req = rst && (state == IDLE) && all_ready;
  assign dfu2idu_load_instr_req    = req;
  assign dfu2idu_compute_instr_req = req;
  assign dfu2idu_store_instr_req   = req;

  assign load_start    = start_q[0];
  assign compute_start = start_q[1];
  assign store_start   = start_q[2];
  assign load_instr    = instr_q[0];
  assign compute_instr = instr_q[1];
  assign store_instr   = instr_q[2];
  assign dfu_lsc_done  = (state == DONE);
  assign lsc_busy      = (state != IDLE);

`ifdef LSC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Limit hit on the cycle the count reaches TIMEOUT_CYCLES, so IDLE and the flag appear then.
  assign tmo = in_phase && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (|start_nxt)    wd_cnt <= '0;
      else if (in_phase) wd_cnt <= wd_cnt + 1'b1;
      if (tmo && state_nxt == IDLE) err_q <= 1'b1;
    end
  end

  assign lsc_timeout_err = err_q;
`else
  assign tmo             = 1'b0;
  assign lsc_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dfu_lsc_sequencer.sv
// Bench for dfu_lsc_sequencer: table of fetch/done timings with a scoreboard of expected triples,
// plus hand sequences for empty gating, reset mid-compute and (with LSC_TIMEOUT_EN) the watchdog.
module tb_dfu_lsc_sequencer;
  localparam int W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic le, ce, se, lreq, creq, sreq, lv, cv, sv;
  logic [W-1:0] l_in, c_in, s_in, l_o, c_o, s_o;
  logic lstart, cstart, sstart, ld, cd, sd, lsc_done, busy, err;

  dfu_lsc_sequencer #(.INSTR_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .idu2dfu_load_fifo_empty(le), .idu2dfu_compute_fifo_empty(ce), .idu2dfu_store_fifo_empty(se),
    .dfu2idu_load_instr_req(lreq), .dfu2idu_compute_instr_req(creq), .dfu2idu_store_instr_req(sreq),
    .idu2dfu_load_instr(l_in), .idu2dfu_compute_instr(c_in), .idu2dfu_store_instr(s_in),
    .idu2dfu_load_instr_vld(lv), .idu2dfu_compute_instr_vld(cv), .idu2dfu_store_instr_vld(sv),
    .load_start(lstart), .compute_start(cstart), .store_start(sstart),
    .load_instr(l_o), .compute_instr(c_o), .store_instr(s_o),
    .load_done(ld), .compute_done(cd), .store_done(sd),
    .dfu_lsc_done(lsc_done), .lsc_busy(busy), .lsc_timeout_err(err)
  );

  // Cycle offsets are relative to the cycle the empties drop (the request cycle).
  typedef struct {
    int dl, dc, ds;          // vld cycle per queue
    int dd_l, dd_c, dd_s;    // done delay after start
    bit early, noise;        // compute_done in start cycle / stray vld+done in LOAD entry
    int e_ls, e_cs, e_ss, e_dn;
  } vec_t;

  typedef struct {
    logic [W-1:0] li, ci, si;
    int dn;
  } sb_t;

  vec_t tbl [6];
  sb_t  sb [$];
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] pa, pb, pc;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    le = 1'b1; ce = 1'b1; se = 1'b1;
    lv = 1'b0; cv = 1'b0; sv = 1'b0;
    ld = 1'b0; cd = 1'b0; sd = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    logic [W-1:0] li, ci, si;
    sb_t e;
    int eL = -1, eC = -1, eS = -1, rq = -1, nany = 0, nall = 0, drift = 0;
    bit fin = 1'b0;
    li = pa ^ W'(idx + 1);
    ci = pb ^ W'(idx + 1);
    si = pc ^ W'(idx + 1);
    e.li = li; e.ci = ci; e.si = si; e.dn = v.e_dn;
    sb.push_back(e);
    for (int k = 0; k < 64 && !fin; k++) begin
      @(posedge clk); #1;
      le = (k != 0); ce = (k != 0); se = (k != 0);
      lv = (k == v.dl); cv = (k == v.dc); sv = (k == v.ds);
      l_in = lv ? li : W'($urandom);
      c_in = cv ? ci : W'($urandom);
      s_in = sv ? si : W'($urandom);
      ld = (eL >= 0) && (k == eL + v.dd_l);
      cd = ((eC >= 0) && (k == eC + v.dd_c)) || (v.early && k == v.e_cs);
      sd = (eS >= 0) && (k == eS + v.dd_s);
      if (v.noise && k == v.e_ls) begin
        lv = 1'b1; cv = 1'b1; sv = 1'b1; cd = 1'b1; sd = 1'b1;
      end
      @(negedge clk);
      if (lreq | creq | sreq) begin
        nany++;
        if (rq < 0) rq = k;
      end
      if (lreq & creq & sreq) nall++;
      if (lstart) eL = k;
      if (cstart) eC = k;
      if (sstart) eS = k;
      if (eL >= 0 && (l_o !== li || c_o !== ci || s_o !== si)) drift++;
      if (lsc_done) begin
        fin = 1'b1;
        if (sb.size() == 0) chki("scoreboard empty at done", 0, 1);
        else begin
          e = sb.pop_front();
          chk("load_instr", l_o, e.li);
          chk("compute_instr", c_o, e.ci);
          chk("store_instr", s_o, e.si);
          chki("done cycle", k, e.dn);
        end
      end
    end
    if (!fin) chki("dfu_lsc_done within budget", 0, 1);
    chki("req cycle", rq, 0);
    chki("req pulses", nany, 1);
    chki("req all three together", nall, 1);
    chki("load_start cycle", eL, v.e_ls);
    chki("compute_start cycle", eC, v.e_cs);
    chki("store_start cycle", eS, v.e_ss);
    chki("instr drift during phases", drift, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("busy after done", W'(busy), W'(0));
    chk("done one cycle", W'(lsc_done), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int n, te, bz, nd, eL;
    pa = {64{4'hA}};
    pb = {64{4'hB}};
    pc = {64{4'hC}};
    tbl[0] = '{2, 2, 2, 1, 1, 1, 0, 0, 3, 5, 7, 9};
    tbl[1] = '{1, 1, 1, 1, 1, 1, 0, 0, 2, 4, 6, 8};
    tbl[2] = '{5, 7, 2, 1, 1, 1, 0, 0, 8, 10, 12, 14};
    tbl[3] = '{3, 1, 2, 2, 3, 1, 0, 1, 4, 7, 11, 13};
    tbl[4] = '{1, 4, 1, 5, 1, 2, 0, 1, 5, 11, 13, 16};
    tbl[5] = '{1, 1, 1, 1, 3, 1, 1, 0, 2, 4, 8, 10};
    idle_inputs();
    l_in = '0; c_in = '0; s_in = '0;

    // Reset state, with empties low so request gating by reset is exercised.
    le = 1'b0; ce = 1'b0; se = 1'b0;
    #12;
    chk("reset req", W'({lreq, creq, sreq}), W'(0));
    chk("reset start/done/busy/err", W'({lstart, cstart, sstart, lsc_done, busy, err}), W'(0));
    chk("reset instr", l_o | c_o | s_o, '0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;

    // Store queue empty for 10 cycles: no request until it drops.
    @(posedge clk); #1;
    le = 1'b0; ce = 1'b0; se = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (lreq | creq | sreq) n++;
      @(posedge clk); #1;
    end
    chki("req while store empty", n, 0);
    for (int i = 0; i < 6; i++) run_row(tbl[i], i);

    // Reset during COMPUTE.
    @(posedge clk); #1;
    le = 1'b0; ce = 1'b0; se = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    lv = 1'b1; cv = 1'b1; sv = 1'b1;
    l_in = pa; c_in = pb; s_in = pc;
    @(posedge clk); #1;
    lv = 1'b0; cv = 1'b0; sv = 1'b0;
    @(posedge clk); #1;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(negedge clk);
    chk("compute_start before reset", W'(cstart), W'(1));
    @(posedge clk); #1;
    le = 1'b0; ce = 1'b0; se = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid reset req", W'({lreq, creq, sreq}), W'(0));
    chk("mid reset start/done/busy", W'({lstart, cstart, sstart, lsc_done, busy}), W'(0));
    chk("mid reset instr", l_o | c_o | s_o, '0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (lstart | cstart | sstart | lsc_done | busy | lreq) n++;
      @(posedge clk); #1;
    end
    chki("activity after reset release", n, 0);
    run_row(tbl[1], 7);

`ifdef LSC_TIMEOUT_EN
    te = -1; bz = -1; nd = 0; eL = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      le = (k != 0); ce = (k != 0); se = (k != 0);
      lv = (k == 1); cv = (k == 1); sv = (k == 1);
      @(negedge clk);
      if (lstart) eL = k;
      if (err && te < 0) begin
        te = k;
        bz = int'(busy);
      end
      if (lsc_done) nd++;
    end
    chki("timeout load entry", eL, 2);
    chki("timeout err cycle", te, 18);
    chki("timeout back to idle", bz, 0);
    chki("timeout no lsc_done", nd, 0);
    chk("timeout err sticky", W'(err), W'(1));
`else
    te = 0; bz = 0; nd = 0; eL = 0;
    chk("timeout err tied low", W'(err), W'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
